// File: rtl/scheduler_pkg.sv
// Shared definitions for the channel scheduler: FSM state encoding and the
// bit layout of a buffered command word.
package scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_WAIT  = 3'd2,
        S_LOAD  = 3'd3,
        S_FIRE  = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    // Command word, LSB first:
    // fast[7:0] slow[15:8] mode[16] stop[17] start[18] sel[22:19]
    // freq[23 +: DATA_BIT] output[23+DATA_BIT +: DATA_BIT]
    localparam int FAST_LSB  = 0;
    localparam int FAST_W    = 8;
    localparam int SLOW_LSB  = 8;
    localparam int SLOW_W    = 8;
    localparam int MODE_BIT  = 16;
    localparam int STOP_BIT  = 17;
    localparam int START_BIT = 18;
    localparam int SEL_LSB   = 19;
    localparam int SEL_W     = 4;
    localparam int FREQ_LSB  = 23;

    // Total command width for a given pattern field width.
    function automatic int cmd_width(input int data_bit);
        return (2 * data_bit) + 23;
    endfunction

    localparam int DATA_BIT_DEF = 32;
    localparam int CMD_W        = cmd_width(DATA_BIT_DEF);

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous show-ahead FIFO: the oldest entry is always visible on o_head.
// A push while full is only honoured when a pop happens in the same cycle.
module cmd_fifo
    import scheduler_pkg::*;
#(
    parameter int WIDTH = CMD_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == DEPTH_C);
    assign o_empty   = (r_count == {CW{1'b0}});
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);
    assign o_head    = r_mem[r_rd_ptr];

    // Storage array write; contents need no reset since r_count gates reads.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/channel_scheduler.sv
// Buffers decoded command frames and dispatches each one to its target
// channel: config bus load, one-hot load strobe, then start or stop strobe.
// Start/config commands wait for the channel to go idle; stop never waits.
module channel_scheduler
    import scheduler_pkg::*;
#(
    parameter int DATA_BIT   = 32,
    parameter int CH_NUM     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_cmd_valid,
    input  logic [DATA_BIT-1:0] i_output_pattern,
    input  logic [DATA_BIT-1:0] i_freq_pattern,
    input  logic [3:0]          i_sel_out,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_mode,
    input  logic [7:0]          i_slow_period,
    input  logic [7:0]          i_fast_period,
    input  logic [CH_NUM-1:0]   i_ch_busy,
    output logic [DATA_BIT-1:0] o_cfg_output_pattern,
    output logic [DATA_BIT-1:0] o_cfg_freq_pattern,
    output logic                o_cfg_mode,
    output logic [7:0]          o_cfg_slow_period,
    output logic [7:0]          o_cfg_fast_period,
    output logic [CH_NUM-1:0]   o_load,
    output logic [CH_NUM-1:0]   o_start,
    output logic [CH_NUM-1:0]   o_stop,
    output logic                o_fifo_full,
    output logic                o_overflow,
    output logic                o_err_tick
);

    localparam int          CW     = cmd_width(DATA_BIT);
    localparam logic [4:0]  CH_LIM = 5'(CH_NUM);

    state_t              r_state;
    state_t              w_state_next;
    logic [3:0]          r_sel;
    logic [CW-1:0]       w_cmd;
    logic [CW-1:0]       w_head;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_err;
    logic                w_cap_sel;
    logic                w_cap_cfg;
    logic [CH_NUM-1:0]   w_sel_onehot;
    logic [CH_NUM-1:0]   w_head_onehot;
    logic                w_sel_busy;
    logic                w_head_busy;
    logic                w_head_sel_ok;

    logic [DATA_BIT-1:0] w_head_op;
    logic [DATA_BIT-1:0] w_head_fp;
    logic [3:0]          w_head_sel;
    logic                w_head_start;
    logic                w_head_stop;
    logic                w_head_mode;
    logic [7:0]          w_head_slow;
    logic [7:0]          w_head_fast;

    assign w_cmd = {i_output_pattern, i_freq_pattern, i_sel_out, i_start,
                    i_stop, i_mode, i_slow_period, i_fast_period};

    cmd_fifo #(
        .WIDTH (CW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (i_cmd_valid),
        .i_data  (w_cmd),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_op     = w_head[FREQ_LSB + DATA_BIT +: DATA_BIT];
    assign w_head_fp     = w_head[FREQ_LSB +: DATA_BIT];
    assign w_head_sel    = w_head[SEL_LSB +: SEL_W];
    assign w_head_start  = w_head[START_BIT];
    assign w_head_stop   = w_head[STOP_BIT];
    assign w_head_mode   = w_head[MODE_BIT];
    assign w_head_slow   = w_head[SLOW_LSB +: SLOW_W];
    assign w_head_fast   = w_head[FAST_LSB +: FAST_W];
    assign w_head_sel_ok = ({1'b0, w_head_sel} < CH_LIM);

    // One-hot decodes of the latched and head channel index (zero if out of range).
    always_comb begin
        w_sel_onehot  = {CH_NUM{1'b0}};
        w_head_onehot = {CH_NUM{1'b0}};
        for (int n = 0; n < CH_NUM; n++) begin
            w_sel_onehot[n]  = (r_sel == 4'(n));
            w_head_onehot[n] = (w_head_sel == 4'(n));
        end
    end

    assign w_sel_busy  = |(i_ch_busy & w_sel_onehot);
    assign w_head_busy = |(i_ch_busy & w_head_onehot);

    // Dispatch FSM next-state, FIFO pop and capture enables.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_err        = 1'b0;
        w_cap_sel    = 1'b0;
        w_cap_cfg    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_next = S_CHECK;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_CHECK: begin
                if (w_empty) begin
                    w_state_next = S_IDLE;
                end else if (!w_head_sel_ok) begin
                    w_pop        = 1'b1;
                    w_err        = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_head_stop) begin
                    w_cap_sel    = 1'b1;
                    w_state_next = S_STOP;
                end else if (w_head_busy) begin
                    w_cap_sel    = 1'b1;
                    w_state_next = S_WAIT;
                end else begin
                    w_cap_sel    = 1'b1;
                    w_cap_cfg    = 1'b1;
                    w_state_next = S_LOAD;
                end
            end
            S_WAIT: begin
                if (w_sel_busy) begin
                    w_state_next = S_WAIT;
                end else begin
                    w_cap_cfg    = 1'b1;
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_head_start) begin
                    w_state_next = S_FIRE;
                end else begin
                    w_pop        = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_FIRE: begin
                w_pop        = 1'b1;
                w_state_next = S_IDLE;
            end
            S_STOP: begin
                w_pop        = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Target channel latched when the head command leaves S_CHECK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel <= 4'd0;
        end else if (w_cap_sel) begin
            r_sel <= w_head_sel;
        end
    end

    // Shared config bus; updated only on entry to S_LOAD and held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_cfg_output_pattern <= {DATA_BIT{1'b0}};
            o_cfg_freq_pattern   <= {DATA_BIT{1'b0}};
            o_cfg_mode           <= 1'b0;
            o_cfg_slow_period    <= 8'd0;
            o_cfg_fast_period    <= 8'd0;
        end else if (w_cap_cfg) begin
            o_cfg_output_pattern <= w_head_op;
            o_cfg_freq_pattern   <= w_head_fp;
            o_cfg_mode           <= w_head_mode;
            o_cfg_slow_period    <= w_head_slow;
            o_cfg_fast_period    <= w_head_fast;
        end
    end

    // Sticky flag: a tick arrived while full and nothing left the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_overflow <= 1'b0;
        end else if (i_cmd_valid && w_full && !w_pop) begin
            o_overflow <= 1'b1;
        end
    end

    assign o_fifo_full = w_full;
    assign o_err_tick  = w_err;
    assign o_load      = (r_state == S_LOAD) ? w_sel_onehot : {CH_NUM{1'b0}};
    assign o_start     = (r_state == S_FIRE) ? w_sel_onehot : {CH_NUM{1'b0}};
    assign o_stop      = (r_state == S_STOP) ? w_sel_onehot : {CH_NUM{1'b0}};

endmodule

// File: tb/tb_channel_scheduler.sv
// Scoreboard bench for channel_scheduler: each accepted command pushes its
// expected strobe events; a monitor pops and compares whenever a strobe appears.
module tb_channel_scheduler;

    logic        clk;
    logic        rst_n;
    logic        i_cmd_valid;
    logic [31:0] i_output_pattern;
    logic [31:0] i_freq_pattern;
    logic [3:0]  i_sel_out;
    logic        i_start;
    logic        i_stop;
    logic        i_mode;
    logic [7:0]  i_slow_period;
    logic [7:0]  i_fast_period;
    logic [7:0]  i_ch_busy;
    logic [31:0] o_cfg_output_pattern;
    logic [31:0] o_cfg_freq_pattern;
    logic        o_cfg_mode;
    logic [7:0]  o_cfg_slow_period;
    logic [7:0]  o_cfg_fast_period;
    logic [7:0]  o_load;
    logic [7:0]  o_start;
    logic [7:0]  o_stop;
    logic        o_fifo_full;
    logic        o_overflow;
    logic        o_err_tick;

    channel_scheduler #(.DATA_BIT(32), .CH_NUM(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .i_cmd_valid(i_cmd_valid),
        .i_output_pattern(i_output_pattern), .i_freq_pattern(i_freq_pattern),
        .i_sel_out(i_sel_out), .i_start(i_start), .i_stop(i_stop), .i_mode(i_mode),
        .i_slow_period(i_slow_period), .i_fast_period(i_fast_period),
        .i_ch_busy(i_ch_busy),
        .o_cfg_output_pattern(o_cfg_output_pattern), .o_cfg_freq_pattern(o_cfg_freq_pattern),
        .o_cfg_mode(o_cfg_mode), .o_cfg_slow_period(o_cfg_slow_period),
        .o_cfg_fast_period(o_cfg_fast_period), .o_load(o_load), .o_start(o_start),
        .o_stop(o_stop), .o_fifo_full(o_fifo_full), .o_overflow(o_overflow),
        .o_err_tick(o_err_tick)
    );

    // kind: 0 load, 1 start, 2 stop, 3 err
    typedef struct {
        int          kind;
        logic [7:0]  vec;
        logic [31:0] op;
        logic [31:0] fp;
        logic        mode;
        logic [7:0]  slow;
        logic [7:0]  fast;
        int          cyc;
        bit          last;
    } ev_t;

    ev_t         exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          outstanding = 0;
    bit          rand_busy = 1'b0;
    logic [31:0] m_op = 32'd0;
    logic [31:0] m_fp = 32'd0;
    logic        m_mode = 1'b0;
    logic [7:0]  m_slow = 8'd0;
    logic [7:0]  m_fast = 8'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic ev_t mk_ev(input int kind, input logic [7:0] vec, input int c, input bit last);
        ev_t e;
        e.kind = kind; e.vec = vec; e.cyc = c; e.last = last;
        e.op = m_op; e.fp = m_fp; e.mode = m_mode; e.slow = m_slow; e.fast = m_fast;
        return e;
    endfunction

    // Drive one decoder tick; if accepted, record what the scheduler must do with it.
    // d0 = cycles from tick to first strobe, or -1 when timing is not fixed.
    task automatic issue(input logic [3:0] sel, input bit st, input bit sp, input bit md,
                         input logic [7:0] sl, input logic [7:0] fs,
                         input logic [31:0] op, input logic [31:0] fp,
                         input bit acc, input int d0);
        int         c0;
        logic [7:0] oh;
        i_cmd_valid = 1'b1; i_sel_out = sel; i_start = st; i_stop = sp; i_mode = md;
        i_slow_period = sl; i_fast_period = fs; i_output_pattern = op; i_freq_pattern = fp;
        c0 = (d0 < 0) ? -1 : cyc + d0;
        if (acc) begin
            outstanding++;
            if (sel >= 4'd8) begin
                exp_q.push_back(mk_ev(3, 8'h00, c0, 1'b1));
            end else begin
                oh = 8'd1 << sel;
                if (sp) begin
                    exp_q.push_back(mk_ev(2, oh, c0, 1'b1));
                end else begin
                    m_op = op; m_fp = fp; m_mode = md; m_slow = sl; m_fast = fs;
                    exp_q.push_back(mk_ev(0, oh, c0, !st));
                    if (st) exp_q.push_back(mk_ev(1, oh, (c0 < 0) ? -1 : c0 + 1, 1'b1));
                end
            end
        end
        step(1);
        i_cmd_valid = 1'b0;
    endtask

    // Monitor: every strobe or error tick must match the oldest expected event.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && ((o_load | o_start | o_stop) != 8'd0 || o_err_tick)) begin
                ev_t        e;
                logic [3:0] am;
                logic [3:0] em;
                bit         ok;
                am = {o_err_tick, |o_stop, |o_start, |o_load};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_strobe: got mask %b load %h start %h stop %h, expected none (cycle %0d)",
                             am, o_load, o_start, o_stop, cyc);
                end else begin
                    e  = exp_q.pop_front();
                    em = 4'b0001 << e.kind;
                    ok = (am == em) && ((o_load | o_start | o_stop) == e.vec) &&
                         (o_cfg_output_pattern == e.op) && (o_cfg_freq_pattern == e.fp) &&
                         (o_cfg_mode == e.mode) && (o_cfg_slow_period == e.slow) &&
                         (o_cfg_fast_period == e.fast) && (e.cyc < 0 || e.cyc == cyc);
                    if (!ok) begin
                        n_bad++;
                        $display("FAIL event_kind%0d: got mask %b vec %h cyc %0d cfg %h %h %b %h %h; expected mask %b vec %h cyc %0d cfg %h %h %b %h %h",
                                 e.kind, am, o_load | o_start | o_stop, cyc, o_cfg_output_pattern,
                                 o_cfg_freq_pattern, o_cfg_mode, o_cfg_slow_period, o_cfg_fast_period,
                                 em, e.vec, e.cyc, e.op, e.fp, e.mode, e.slow, e.fast);
                    end
                    if (e.last) outstanding--;
                end
            end
        end
    end

    // Background busy noise during the random phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_busy) i_ch_busy = 8'($urandom & $urandom & $urandom);
        end
    end

    initial begin
        int guard;
        rst_n = 1'b0; i_cmd_valid = 1'b0; i_output_pattern = 32'd0; i_freq_pattern = 32'd0;
        i_sel_out = 4'd0; i_start = 1'b0; i_stop = 1'b0; i_mode = 1'b0;
        i_slow_period = 8'd0; i_fast_period = 8'd0; i_ch_busy = 8'd0;
        step(2);
        chk("reset_strobes", {o_load, o_start, o_stop, 7'd0, o_err_tick}, 64'd0);
        chk("reset_flags", {o_fifo_full, o_overflow}, 64'd0);
        chk("reset_cfg", {o_cfg_output_pattern, o_cfg_freq_pattern}, 64'd0);
        rst_n = 1'b1;
        step(2);

        // 1: idle channel, start command, exact latency
        issue(4'd2, 1'b1, 1'b0, 1'b1, 8'h10, 8'h02, 32'hA5A5_0001, 32'h0000_1234, 1'b1, 3);
        step(8);

        // 2: channel 5 busy for 10 cycles after the tick
        i_ch_busy = 8'h20;
        issue(4'd5, 1'b1, 1'b0, 1'b0, 8'h33, 8'h44, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 11);
        step(9);
        i_ch_busy = 8'h00;
        step(8);

        // 3: stop wins over start and ignores busy; cfg must not change
        i_ch_busy = 8'h08;
        issue(4'd3, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hEE, 32'h1111_1111, 32'h2222_2222, 1'b1, 3);
        step(6);
        i_ch_busy = 8'h00;

        // 4: invalid channel then a valid one back-to-back
        issue(4'd9, 1'b1, 1'b0, 1'b0, 8'h01, 8'h01, 32'h3, 32'h4, 1'b1, 2);
        issue(4'd1, 1'b1, 1'b0, 1'b1, 8'h21, 8'h12, 32'h5555_AAAA, 32'h0F0F_F0F0, 1'b1, 4);
        step(8);

        // 5: fill the FIFO behind a busy channel 0, then overflow
        i_ch_busy = 8'h01;
        for (int i = 0; i < 6; i++) begin
            issue(4'd0, (i % 2) == 0, 1'b0, 1'b0, 8'(i), 8'(i + 16), $urandom, $urandom, i < 4, -1);
            if (i == 2) chk("fifo_not_full_3", {63'd0, o_fifo_full}, 64'd0);
            if (i == 3) chk("fifo_full_4", {63'd0, o_fifo_full}, 64'd1);
            if (i == 3) chk("no_overflow_4", {63'd0, o_overflow}, 64'd0);
            if (i >= 4) chk("overflow_set", {63'd0, o_overflow}, 64'd1);
        end
        step(3);
        chk("overflow_sticky", {63'd0, o_overflow}, 64'd1);
        i_ch_busy = 8'h00;
        step(25);
        chk("drain_after_full", 64'(exp_q.size()), 64'd0);
        chk("overflow_held", {63'd0, o_overflow}, 64'd1);

        // 6: reset while waiting on a busy channel
        i_ch_busy = 8'h20;
        issue(4'd5, 1'b1, 1'b0, 1'b1, 8'h99, 8'h88, 32'h7777_7777, 32'h6666_6666, 1'b1, -1);
        step(4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_strobes", {o_load, o_start, o_stop, 7'd0, o_err_tick}, 64'd0);
        chk("rst_async_flags", {o_fifo_full, o_overflow}, 64'd0);
        chk("rst_async_cfg", {o_cfg_output_pattern, o_cfg_freq_pattern}, 64'd0);
        chk("rst_async_cfg2", {o_cfg_mode, o_cfg_slow_period, o_cfg_fast_period}, 64'd0);
        exp_q.delete();
        outstanding = 0;
        m_op = 32'd0; m_fp = 32'd0; m_mode = 1'b0; m_slow = 8'd0; m_fast = 8'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        i_ch_busy = 8'h00;
        step(12);

        // Random phase: never let the FIFO fill, so every tick is accepted
        rand_busy = 1'b1;
        for (int k = 0; k < 120; k++) begin
            guard = 0;
            while (outstanding >= 3 && guard < 500) begin
                step(1);
                guard++;
            end
            if (guard >= 500) begin
                chk("random_progress_timeout", 64'(outstanding), 64'd0);
                break;
            end
            issue(4'($urandom_range(0, 9)), 1'($urandom), 1'(($urandom % 4) == 0), 1'($urandom),
                  8'($urandom), 8'($urandom), $urandom, $urandom, 1'b1, -1);
            step($urandom_range(0, 3));
        end
        rand_busy = 1'b0;
        i_ch_busy = 8'h00;
        guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            step(1);
            guard++;
        end
        chk("random_drain", 64'(exp_q.size()), 64'd0);
        step(5);
        chk("final_no_overflow", {63'd0, o_overflow}, 64'd0);
        chk("final_not_full", {63'd0, o_fifo_full}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/channel_scheduler.md
Name: channel_scheduler

Overview:
Sits between the UART frame decoder and the bank of serial-output channels. It buffers decoded command frames in a small FIFO and routes each one to the channel selected by its sel_out field. For each command it loads the shared config bus, then issues a one-hot load strobe followed by a start or stop strobe. A start/config command is held back until the target channel reports idle.

Parameters:
DATA_BIT, 32, width of output/frequency pattern fields
CH_NUM, 8, number of output channels (1..16); sel_out values >= CH_NUM are invalid
FIFO_DEPTH, 4, command FIFO depth (power of 2, >= 2)

Ports:
clk  in  1  system clock
rst_n  in  1  async active-low reset
i_cmd_valid  in  1  one-cycle frame-done tick from decoder; pushes one command
i_output_pattern  in  DATA_BIT  output pattern field
i_freq_pattern  in  DATA_BIT  frequency pattern field
i_sel_out  in  4  target channel index
i_start  in  1  start request
i_stop  in  1  stop request
i_mode  in  1  channel mode
i_slow_period  in  8  slow period
i_fast_period  in  8  fast period
i_ch_busy  in  CH_NUM  per-channel busy, bit n = channel n running
o_cfg_output_pattern  out  DATA_BIT  shared config bus
o_cfg_freq_pattern  out  DATA_BIT  shared config bus
o_cfg_mode  out  1  shared config bus
o_cfg_slow_period  out  8  shared config bus
o_cfg_fast_period  out  8  shared config bus
o_load  out  CH_NUM  one-hot; channel latches config bus
o_start  out  CH_NUM  one-hot start strobe
o_stop  out  CH_NUM  one-hot stop strobe
o_fifo_full  out  1  FIFO full
o_overflow  out  1  sticky; a command was dropped because the FIFO was full
o_err_tick  out  1  one-cycle pulse; a command with invalid sel_out was discarded

Behaviour:
- Reset (async, rst_n=0): FIFO empty, state S_IDLE, every output 0, o_overflow cleared. Reset mid-command abandons it; no strobe fires afterwards.
- FIFO: command = {output_pattern, freq_pattern, sel_out, start, stop, mode, slow, fast}, 2*DATA_BIT+23 bits. Head is show-ahead.
  - Push on i_cmd_valid when not full, or when full with a pop in the same cycle.
  - Push when full without a pop: command dropped, o_overflow set to 1 and held until reset.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM (3-bit state):
  - S_IDLE: FIFO non-empty -> S_CHECK.
  - S_CHECK: evaluate head.
    - sel_out >= CH_NUM: pop, o_err_tick=1 this cycle, -> S_IDLE.
    - Else stop=1 (stop wins over start): -> S_STOP.
    - Else i_ch_busy[sel]=1: -> S_WAIT.
    - Else: -> S_LOAD.
    - On every exit to S_LOAD, capture head fields into the o_cfg_* registers and sel_reg.
  - S_WAIT: stay while i_ch_busy[sel_reg]=1. When it clears, capture cfg and go to S_LOAD. No timeout; the FIFO keeps accepting pushes meanwhile.
  - S_LOAD: o_load[sel_reg]=1 for one cycle. start=1 -> S_FIRE; else pop -> S_IDLE.
  - S_FIRE: o_start[sel_reg]=1 for one cycle, pop, -> S_IDLE.
  - S_STOP: o_stop[sel_reg]=1 for one cycle, pop, -> S_IDLE. Stop never waits on busy and never touches the cfg bus.
  - Undefined state -> S_IDLE.
- o_cfg_* are registered and hold their value between loads. o_load, o_start and o_stop are Moore decodes of state_reg and sel_reg: one-hot or zero, never more than one bit set.
- Latency, with the tick in cycle 0 and an idle channel: CHECK in cycle 2, o_load in cycle 3, o_start in cycle 4, next head checked in cycle 6. A stop command produces o_stop in cycle 3.
- Back-to-back ticks are legal; commands execute strictly in order.

Decomposition:
- Package scheduler_pkg: state encodings; command field offsets and widths; CMD_W = 2*DATA_BIT+23.
- Sub-module cmd_fifo (parameters WIDTH, DEPTH): synchronous show-ahead FIFO with full/empty flags and push/pop ports. The overflow flag lives in the top level.

Test Plan:
1. Tick with sel=2, start=1, mode=1, slow=8'h10, fast=8'h02, busy=0 -> o_cfg_* valid from cycle 3; o_load=8'h04 in cycle 3; o_start=8'h04 in cycle 4; no o_stop.
2. sel=5, start=1, i_ch_busy[5]=1 held 10 cycles -> no o_load while busy; o_load=8'h20 one cycle after busy falls, then o_start=8'h20.
3. sel=3 with start=1 and stop=1 while busy[3]=1 -> o_stop=8'h08 in cycle 3; o_load and o_start stay 0; o_cfg_* unchanged.
4. sel=9 with CH_NUM=8 -> o_err_tick=1 in cycle 2, no strobes; the next valid command executes normally.
5. busy[0]=1 held; push 6 commands to sel=0 with FIFO_DEPTH=4 -> o_fifo_full=1 after 4 pushes, o_overflow=1 after the 5th and stays set. Release busy -> exactly 4 loads in push order.
6. Assert rst_n=0 during S_WAIT -> all outputs 0 immediately. After release, no strobe fires until a new tick arrives.
